rect_plotter: RTL and testbench

RECT_PLOTTER -- requirements
Module: rect_plotter

---
 rtl/rect_plotter.sv | 115 +++++++++++
 tb/tb_rect_plotter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/rect_plotter.sv
// rect_plotter: fills a w x h rectangle one pixel per cycle for a VGA adapter.
// Ports: clk; reset (asynchronous, active-high); start, x0, y0, w, h, color (request);
//        x_out, y_out, color_out, writeEn (pixel stream); busy, done (status).
// Option: define RECT_PLOTTER_CLIP_EN to suppress writeEn for pixels outside 160x120.
module rect_plotter #(
    parameter int MAX_W = 16,
    parameter int MAX_H = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    input  logic [4:0] w,
    input  logic [4:0] h,
    input  logic [2:0] color,
    output logic [7:0] x_out,
    output logic [6:0] y_out,
    output logic [2:0] color_out,
    output logic       writeEn,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;
    localparam logic [4:0] MW = 5'(MAX_W);
    localparam logic [4:0] MH = 5'(MAX_H);
    state_t state, state_nx;
    logic [7:0] xr, base_x, nx_x;
    logic [6:0] yr, base_y, nx_y;
    logic [2:0] cr, base_c;
    logic [4:0] wr, hr, col, row, col_nx, row_nx, cw, ch;
    logic       plot, vis, last_col, last_row, accept;

    assign cw = (w > MW) ? MW : w;
    assign ch = (h > MH) ? MH : h;
    assign accept = state == IDLE && start;
    assign last_col = col == wr - 5'd1;
    assign last_row = row == hr - 5'd1;
    // Coordinates of the pixel presented on the next cycle; base is the live
    // request inputs when a request is accepted, otherwise the latched origin.
    assign nx_x = base_x + {3'd0, col_nx};
    assign nx_y = base_y + {2'd0, row_nx};
`ifdef RECT_PLOTTER_CLIP_EN
    assign vis = ({1'b0, base_x} + {4'd0, col_nx}) <= 9'd159 &&
                 ({1'b0, base_y} + {3'd0, row_nx}) <= 8'd119;
`else
    assign vis = 1'b1;
`endif

    always_comb begin
        state_nx = state;
        col_nx = col;
        row_nx = row;
        base_x = xr;
        base_y = yr;
        base_c = cr;
        plot = 1'b0;
        case (state)
            IDLE: if (start) begin
                plot = cw != 5'd0 && ch != 5'd0;
                state_nx = plot ? DRAW : FINISH;
                col_nx = '0;
                row_nx = '0;
                base_x = x0;
                base_y = y0;
                base_c = color;
            end
            DRAW: begin
                plot = !(last_col && last_row);
                state_nx = plot ? DRAW : FINISH;
                col_nx = last_col ? 5'd0 : col + 5'd1;
                row_nx = last_col ? row + 5'd1 : row;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            xr <= '0;
            yr <= '0;
            cr <= '0;
            wr <= '0;
            hr <= '0;
            x_out <= '0;
            y_out <= '0;
            color_out <= '0;
            writeEn <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_nx;
            col <= col_nx;
            row <= row_nx;
            busy <= state_nx != IDLE;
            done <= state == FINISH;
            writeEn <= plot && vis;
            if (plot) begin
                x_out <= nx_x;
                y_out <= nx_y;
                color_out <= base_c;
            end
            if (accept) begin
                xr <= x0;
                yr <= y0;
                cr <= color;
                wr <= cw;
                hr <= ch;
            end
        end
    end
endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter: directed and randomized checks of rect_plotter against a pixel-list model.
module tb_rect_plotter;
    localparam int MW = 16;
    localparam int MH = 16;
    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [4:0] w, h;
    logic [2:0] color;
    logic [7:0] x_out;
    logic [6:0] y_out;
    logic [2:0] color_out;
    logic       writeEn, busy, done;
    int checks = 0;
    int errors = 0;
    int lx = 0, ly = 0, lc = 0;

    always #5 clk = ~clk;

    rect_plotter #(.MAX_W(MW), .MAX_H(MH)) dut (
        .clk(clk), .reset(reset), .start(start), .x0(x0), .y0(y0), .w(w), .h(h),
        .color(color), .x_out(x_out), .y_out(y_out), .color_out(color_out),
        .writeEn(writeEn), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected behaviour: the clamped rectangle is a row-major list of w*h pixels,
    // one per cycle starting the cycle after start, then one busy idle cycle,
    // then a done cycle with busy low.
    task automatic run_req(input int x, input int y, input int ww, input int hh,
                           input int c, input bit hold, input bit glitch);
        int cw, ch, n, px, py;
        bit we;
        cw = ww < MW ? ww : MW;
        ch = hh < MH ? hh : MH;
        n = cw * ch;
        start = 1'b1;
        x0 = 8'(x);
        y0 = 7'(y);
        w = 5'(ww);
        h = 5'(hh);
        color = 3'(c);
        for (int k = 1; k <= n + 2; k++) begin
            @(negedge clk);
            if (!hold) start = glitch && k == 3;
            if (glitch && k == 3) begin
                x0 = 8'($urandom);
                y0 = 7'($urandom);
                w = 5'd1;
                h = 5'd1;
                color = 3'(~c);
            end
            we = 1'b0;
            if (k <= n) begin
                px = x + (k - 1) % cw;
                py = y + (k - 1) / cw;
`ifdef RECT_PLOTTER_CLIP_EN
                we = px <= 159 && py <= 119;
`else
                we = 1'b1;
`endif
                lx = px % 256;
                ly = py % 128;
                lc = c;
            end
            chk("writeEn", writeEn, we);
            chk("busy", busy, k <= n + 1);
            chk("done", done, k == n + 2);
            chk("x_out", x_out, lx);
            chk("y_out", y_out, ly);
            chk("color_out", color_out, lc);
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            chk("idle_writeEn", writeEn, 0);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
            chk("idle_x_out", x_out, lx);
            chk("idle_y_out", y_out, ly);
            chk("idle_color_out", color_out, lc);
        end
    endtask

    initial begin
        bit hold;
        reset = 1'b0;
        start = 1'b0;
        x0 = '0;
        y0 = '0;
        w = '0;
        h = '0;
        color = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_writeEn", writeEn, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x_out", x_out, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_color_out", color_out, 0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);
        run_req(10, 20, 2, 2, 5, 0, 0);
        idle(1);
        run_req(50, 30, 0, 5, 2, 0, 0);
        idle(1);
        run_req(60, 30, 4, 0, 3, 0, 0);
        idle(1);
        run_req(0, 3, 31, 1, 6, 0, 1);
        idle(2);
        run_req(158, 119, 3, 2, 4, 0, 0);
        idle(1);
        run_req(250, 126, 17, 3, 1, 0, 0);
        idle(1);
        run_req(7, 9, 3, 2, 3, 1, 0);
        run_req(7, 9, 3, 2, 3, 0, 0);
        idle(2);
        start = 1'b1;
        x0 = 8'd30;
        y0 = 7'd40;
        w = 5'd4;
        h = 5'd4;
        color = 3'd7;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_writeEn", writeEn, 1);
        chk("pre_rst_x_out", x_out, 32);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_writeEn", writeEn, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_x_out", x_out, 0);
        chk("async_rst_y_out", y_out, 0);
        chk("async_rst_color_out", color_out, 0);
        @(negedge clk);
        reset = 1'b0;
        lx = 0;
        ly = 0;
        lc = 0;
        idle(3);
        run_req(100, 100, 1, 1, 1, 0, 0);
        idle(2);
        for (int i = 0; i < 25; i++) begin
            hold = $urandom_range(0, 3) == 0;
            run_req(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 7)), hold, 0);
            if (!hold) idle(int'($urandom_range(0, 2)));
        end
        start = 1'b0;
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
